// File: rtl/jedro_1_core.sv
// Minimal non-pipelined RV32I core (OP, OP-IMM, LUI, AUIPC) with a 3-state fetch/wait/exec sequence.
// The register file is a separate module so it can be reached as regfile_inst.regfile.

module jedro_1_regfile #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [4:0]            waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [4:0]            raddr1_i,
  input  logic [4:0]            raddr2_i,
  output logic [DATA_WIDTH-1:0] rdata1_o,
  output logic [DATA_WIDTH-1:0] rdata2_o
);
  logic [DATA_WIDTH-1:0] regfile [0:31];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 32; i++) regfile[i] <= '0;
    end else if (we_i && (waddr_i != 5'd0)) begin
      regfile[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = (raddr1_i == 5'd0) ? '0 : regfile[raddr1_i];
  assign rdata2_o = (raddr2_i == 5'd0) ? '0 : regfile[raddr2_i];
endmodule

module jedro_1_core #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  output logic [ADDR_WIDTH-1:0] instr_addr_o,
  input  logic [DATA_WIDTH-1:0] instr_rdata_i,
  output logic [ADDR_WIDTH-1:0] data_addr_o,
  output logic [DATA_WIDTH-1:0] data_wdata_o,
  output logic [3:0]            data_we_o,
  input  logic [DATA_WIDTH-1:0] data_rdata_i
);
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  typedef enum logic [1:0] {FETCH, WAIT, EXEC} state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] ir_q;

  logic [6:0]            opcode, funct7;
  logic [2:0]            funct3;
  logic [4:0]            rd, rs1, rs2, shamt;
  logic [DATA_WIDTH-1:0] imm_i, imm_u, op_a, op_b, rs1_data, rs2_data, alu_res, rd_wdata;
  logic                  is_op, alt, legal, rd_we;
  logic                  unused_data_rdata;

  assign pc_d = pc_q + ADDR_WIDTH'(4);

  // Sequencer: the ROM needs one cycle to register the address, one to return the word.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      case (state_q)
        FETCH:   state_q <= WAIT;
        WAIT: begin
          ir_q    <= instr_rdata_i;
          state_q <= EXEC;
        end
        EXEC: begin
          pc_q    <= pc_d;
          state_q <= FETCH;
        end
        default: state_q <= FETCH;
      endcase
    end
  end

  assign opcode = ir_q[6:0];
  assign rd     = ir_q[11:7];
  assign funct3 = ir_q[14:12];
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];
  assign funct7 = ir_q[31:25];
  assign imm_i  = {{(DATA_WIDTH-12){ir_q[31]}}, ir_q[31:20]};
  assign imm_u  = {ir_q[31:12], 12'b0};

  jedro_1_regfile #(.DATA_WIDTH(DATA_WIDTH)) regfile_inst (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .we_i     (rd_we),
    .waddr_i  (rd),
    .wdata_i  (rd_wdata),
    .raddr1_i (rs1),
    .raddr2_i (rs2),
    .rdata1_o (rs1_data),
    .rdata2_o (rs2_data)
  );

  assign is_op = (opcode == OPC_OP);
  assign alt   = (funct7 == F7_ALT);
  assign op_a  = rs1_data;
  assign op_b  = is_op ? rs2_data : imm_i;
  assign shamt = op_b[4:0];

  // Shared ALU for OP and OP-IMM; funct7 only selects SUB (OP) and arithmetic right shift.
  always_comb begin
    alu_res = '0;
    case (funct3)
      3'b000:  alu_res = (is_op && alt) ? op_a - op_b : op_a + op_b;
      3'b001:  alu_res = op_a << shamt;
      3'b010:  alu_res = DATA_WIDTH'($signed(op_a) < $signed(op_b));
      3'b011:  alu_res = DATA_WIDTH'(op_a < op_b);
      3'b100:  alu_res = op_a ^ op_b;
      3'b101:  alu_res = alt ? DATA_WIDTH'($signed(op_a) >>> shamt) : op_a >> shamt;
      3'b110:  alu_res = op_a | op_b;
      default: alu_res = op_a & op_b;
    endcase
  end

  // Decode legality and writeback value; anything unrecognised retires as a NOP.
  always_comb begin
    legal    = 1'b0;
    rd_wdata = '0;
    case (opcode)
      OPC_OP: begin
        legal    = (funct7 == 7'b0) || (alt && ((funct3 == 3'b000) || (funct3 == 3'b101)));
        rd_wdata = alu_res;
      end
      OPC_OPIMM: begin
        if (funct3 == 3'b001)      legal = (funct7 == 7'b0);
        else if (funct3 == 3'b101) legal = (funct7 == 7'b0) || alt;
        else                       legal = 1'b1;
        rd_wdata = alu_res;
      end
      OPC_LUI: begin
        legal    = 1'b1;
        rd_wdata = imm_u;
      end
      OPC_AUIPC: begin
        legal    = 1'b1;
        rd_wdata = DATA_WIDTH'(pc_q) + imm_u;
      end
      default: ;
    endcase
  end

  assign rd_we = (state_q == EXEC) && legal;

  assign instr_addr_o      = pc_q;
  assign data_addr_o       = '0;
  assign data_wdata_o      = '0;
  assign data_we_o         = '0;
  assign unused_data_rdata = ^data_rdata_i;
endmodule

// File: tb/tb_jedro_1_core.sv
// Self-checking bench for jedro_1_core: behavioural ROM, per-program expected register
// values queued when the program is loaded and compared after it has run.

module tb_jedro_1_core;
  localparam logic [6:0] OP = 7'b0110011, LUI = 7'b0110111, AUIPC = 7'b0010111;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr_addr, instr_rdata, data_addr, data_wdata, data_rdata;
  logic [3:0]  data_we;
  logic [31:0] rom [0:63];

  typedef struct {
    string       tag;
    int          idx;
    logic [31:0] exp;
  } sb_t;

  sb_t         sb[$];
  logic [31:0] addr_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  jedro_1_core dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .instr_addr_o  (instr_addr),
    .instr_rdata_i (instr_rdata),
    .data_addr_o   (data_addr),
    .data_wdata_o  (data_wdata),
    .data_we_o     (data_we),
    .data_rdata_i  (data_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) instr_rdata <= rom[instr_addr[7:2]];

  assign data_rdata = 32'hDEADBEEF;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rf(input int i);
    return dut.regfile_inst.regfile[i];
  endfunction

  function automatic logic [31:0] r_t(input logic [6:0] f7, input logic [4:0] rs2,
                                      input logic [4:0] rs1, input logic [2:0] f3,
                                      input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, OP};
  endfunction

  function automatic logic [31:0] i_t(input logic [11:0] imm, input logic [4:0] rs1,
                                      input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] u_t(input logic [19:0] imm, input logic [4:0] rd,
                                      input logic [6:0] opc);
    return {imm, rd, opc};
  endfunction

  task automatic expect_reg(input string tag, input int idx, input logic [31:0] v);
    sb_t e;
    e.tag = tag; e.idx = idx; e.exp = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    sb_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, rf(e.idx), e.exp);
    end
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic reset_and_load(input logic [31:0] prog[$]);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 64; i++) rom[i] = 32'h0;
    for (int i = 0; i < prog.size(); i++) rom[i] = prog[i];
    run(3);
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] p[$];

    // Reset state, fetch cadence and SUB program
    p = '{i_t(12'd5, 5'd0, 3'b000, 5'd5), i_t(12'd3, 5'd0, 3'b000, 5'd6),
          r_t(7'b0100000, 5'd6, 5'd5, 3'b000, 5'd1), r_t(7'b0100000, 5'd5, 5'd6, 3'b000, 5'd2),
          r_t(7'b0100000, 5'd5, 5'd5, 3'b000, 5'd3), r_t(7'b0100000, 5'd1, 5'd0, 3'b000, 5'd4),
          i_t(12'hFFB, 5'd0, 3'b000, 5'd7), r_t(7'b0100000, 5'd0, 5'd7, 3'b000, 5'd10)};
    reset_and_load(p);
    check("rst_addr", instr_addr, 32'h0);
    check("rst_data", {data_addr ^ data_wdata, 28'h0, data_we}, 32'h0);
    for (int i = 0; i < 32; i++) expect_reg($sformatf("rst_x%0d", i), i, 32'h0);
    drain();
    addr_q = '{32'h0, 32'h4, 32'h8};
    release_rst();
    for (int k = 0; k < 3; k++) begin
      run(1);
      check("fetch_addr", instr_addr, addr_q.pop_front());
      run(2);
    end
    expect_reg("sub_x1", 1, 32'h2);
    expect_reg("sub_x2", 2, 32'hFFFFFFFE);
    expect_reg("sub_x3", 3, 32'h0);
    expect_reg("sub_x4", 4, 32'hFFFFFFFE);
    expect_reg("sub_x10", 10, 32'hFFFFFFFB);
    run(18);
    drain();
    check("data_idle", {data_addr | data_wdata, 28'h0, data_we}, 32'h0);

    // x0 protection
    p = '{i_t(12'd7, 5'd0, 3'b000, 5'd0), r_t(7'b0, 5'd0, 5'd0, 3'b000, 5'd1)};
    reset_and_load(p);
    expect_reg("x0_x0", 0, 32'h0);
    expect_reg("x0_x1", 1, 32'h0);
    release_rst();
    run(9);
    drain();

    // Wrap and signed/unsigned compare
    p = '{u_t(20'h80000, 5'd1, LUI), i_t(12'hFFF, 5'd1, 3'b000, 5'd2),
          r_t(7'b0, 5'd2, 5'd1, 3'b010, 5'd3), r_t(7'b0, 5'd2, 5'd1, 3'b011, 5'd4)};
    reset_and_load(p);
    expect_reg("wrap_x1", 1, 32'h80000000);
    expect_reg("wrap_x2", 2, 32'h7FFFFFFF);
    expect_reg("slt_x3", 3, 32'h1);
    expect_reg("sltu_x4", 4, 32'h0);
    release_rst();
    run(15);
    drain();

    // Immediate shifts
    p = '{i_t(12'hFF0, 5'd0, 3'b000, 5'd1), i_t({7'b0100000, 5'd2}, 5'd1, 3'b101, 5'd2),
          i_t({7'b0, 5'd28}, 5'd1, 3'b101, 5'd3), i_t({7'b0, 5'd31}, 5'd1, 3'b001, 5'd4)};
    reset_and_load(p);
    expect_reg("shf_x1", 1, 32'hFFFFFFF0);
    expect_reg("srai_x2", 2, 32'hFFFFFFFC);
    expect_reg("srli_x3", 3, 32'h0000000F);
    expect_reg("slli_x4", 4, 32'h0);
    release_rst();
    run(15);
    drain();

    // Logic ops, AUIPC, register shifts, compares and an invalid funct7
    p = '{i_t(12'h0F0, 5'd0, 3'b000, 5'd1), i_t(12'h0FF, 5'd0, 3'b000, 5'd2),
          i_t(12'hFFF, 5'd1, 3'b100, 5'd3), r_t(7'b0, 5'd2, 5'd1, 3'b110, 5'd4),
          r_t(7'b0, 5'd2, 5'd1, 3'b111, 5'd5), u_t(20'h00001, 5'd6, AUIPC),
          r_t(7'b0, 5'd1, 5'd2, 3'b001, 5'd7), i_t(12'hFFF, 5'd0, 3'b000, 5'd9),
          r_t(7'b0, 5'd1, 5'd3, 3'b101, 5'd10), r_t(7'b0100000, 5'd1, 5'd3, 3'b101, 5'd16),
          i_t(12'h7FF, 5'd9, 3'b111, 5'd11), i_t(12'h800, 5'd0, 3'b110, 5'd12),
          i_t(12'hFFF, 5'd1, 3'b011, 5'd13), i_t(12'hFFF, 5'd1, 3'b010, 5'd14),
          i_t(12'h000, 5'd9, 3'b010, 5'd17), r_t(7'b0000001, 5'd2, 5'd1, 3'b000, 5'd15)};
    reset_and_load(p);
    expect_reg("xori_x3", 3, 32'hFFFFFF0F);
    expect_reg("or_x4", 4, 32'h000000FF);
    expect_reg("and_x5", 5, 32'h000000F0);
    expect_reg("auipc_x6", 6, 32'h00001014);
    expect_reg("sll_x7", 7, 32'h00FF0000);
    expect_reg("srl_x10", 10, 32'h0000FFFF);
    expect_reg("sra_x16", 16, 32'hFFFFFFFF);
    expect_reg("andi_x11", 11, 32'h000007FF);
    expect_reg("ori_x12", 12, 32'hFFFFF800);
    expect_reg("sltiu_x13", 13, 32'h1);
    expect_reg("slti_x14", 14, 32'h0);
    expect_reg("slti_x17", 17, 32'h1);
    expect_reg("badf7_x15", 15, 32'h0);
    release_rst();
    run(51);
    drain();

    // Illegal word is a NOP; reset during EXEC aborts the pending write
    p = '{i_t(12'd1, 5'd0, 3'b000, 5'd1), 32'h00000000, i_t(12'd2, 5'd0, 3'b000, 5'd2)};
    reset_and_load(p);
    release_rst();
    run(6);
    check("ill_pc", instr_addr, 32'h8);
    expect_reg("ill_x1", 1, 32'h1);
    for (int i = 2; i < 32; i++) expect_reg($sformatf("ill_x%0d", i), i, 32'h0);
    drain();
    run(2);
    rst = 1'b1;
    #2;
    check("abort_pc", instr_addr, 32'h0);
    expect_reg("abort_x2", 2, 32'h0);
    drain();
    release_rst();
    run(1);
    check("restart_pc0", instr_addr, 32'h0);
    run(2);
    check("restart_pc4", instr_addr, 32'h4);
    expect_reg("restart_x1", 1, 32'h1);
    expect_reg("restart_x2", 2, 32'h0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
